demux_1_4_stream: RTL and testbench
===================================

Name: demux_1_4_stream

Overview:
- Parameterised 1-to-4 stream demultiplexer: the inverse of the team's 4-to-1 mux.
- Accepts one input word plus a 2-bit select over a valid/ready handshake and routes it to one of four registered output channels. Each output channel has its own valid/ready handshake.
- Sits between a single producer (e.g. UART RX / lab datapath) and four independent consumers.
- Each channel has a one-entry output register, so a stalled consumer blocks only traffic addressed to it.

Parameters:
- DATA_WIDTH, 16, width of the data word on the input and on every output channel (must be >= 1).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  DATA_WIDTH  input word.
- in_sel  input  2  destination channel, 0..3.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  block accepts the word this cycle.
- out0, out1, out2, out3  output  DATA_WIDTH each  per-channel registered data.
- out_valid  output  4  bit k high = outk holds an undelivered word.
- out_ready  input  4  bit k high = consumer k takes outk this cycle.
- stat_cnt  output  64  four 16-bit delivered-word counters; port exists only with DEMUX_STATS_EN (see Optional Feature).

Behaviour:
- Reset is synchronous: on a rising clk edge with rst_n=0, out_valid=4'b0000 and out0..out3 = 0. Any pending words are discarded, including mid-transfer.
- in_ready is combinational: in_ready = !out_valid[in_sel] | out_ready[in_sel]. It is 0 while rst_n=0.
- Input transfer occurs when in_valid & in_ready on a rising edge.
  - in_sel is sampled only at a transfer.
  - in_data and in_sel must stay stable while in_valid=1 and in_ready=0.
- Output transfer on channel k occurs when out_valid[k] & out_ready[k] on a rising edge.
- Latency: a word accepted at edge N appears on outk with out_valid[k]=1 after edge N. It is visible in cycle N+1 at the earliest.
- Per-channel next state, evaluated every edge:
  - Load only (input transfer to k, no output transfer on k): outk <= in_data, out_valid[k] <= 1.
  - Drain only (output transfer on k, no input transfer to k): out_valid[k] <= 0. outk holds its old value.
  - Load and drain in the same edge: outk <= in_data, out_valid[k] stays 1. There is no bubble, so full throughput is one word/cycle per channel.
  - Neither: hold.
- Channels are independent. Channel j != in_sel drains while the selected channel is stalled.
- Full channel with out_ready[k]=0: in_ready=0 for words selecting k. No word is ever overwritten or dropped.
- Data on a channel with out_valid=0 is don't-care for the consumer. RTL holds the last delivered value (not zeroed).
- out_ready asserted on an empty channel has no effect.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.

Optional Feature:
- Macro DEMUX_STATS_EN.
- Defined:
  - Port stat_cnt[64] exists. Bits [16k+15:16k] count output transfers on channel k.
  - Counters reset to 0 and increment by 1 on each output transfer on k.
  - Counters wrap 16'hFFFF -> 16'h0000.
  - Counters reset synchronously with rst_n like the rest of the block.
- Undefined: the port and the counters are absent, and datapath behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0000, out0..3=0, in_ready=0. After release with out_valid=0000, in_ready=1.
- Routing, DATA_WIDTH=16, out_ready=1111: send 16'hA0A0/sel0, 16'hB1B1/sel1, 16'hC2C2/sel2, 16'hD3D3/sel3 back-to-back -> each word appears one cycle after acceptance on the matching outk with only that valid bit set. in_ready stays 1 throughout.
- Backpressure: out_ready=0000, send 16'h1111 to ch2, then 16'h2222 to ch2 -> second word held with in_ready=0 and out2 stays 1111. Raise out_ready[2] -> the same edge drains 1111 and loads 2222, and out_valid[2] stays 1.
- Channel independence: ch0 full and stalled; send 16'h5555 to ch3 with out_ready[3]=1 -> accepted immediately and delivered on out3. out0 is unchanged.
- Reset mid-operation: ch1 and ch3 full, assert rst_n=0 for one edge -> out_valid=0000. No stale word is delivered afterwards.
- Random/stats (DEMUX_STATS_EN): 1000 random words, random sel, random out_ready, checked against per-channel scoreboard queues -> zero mismatches and no loss. stat_cnt fields equal the scoreboard per-channel counts mod 2^16. Preload 65535 transfers on ch0 -> wrap to 0 checked.

Source files
------------

// File: rtl/demux_1_4_stream.sv
// Purpose : 1-to-4 stream demux; routes each accepted word to the one-entry register of channel in_sel.
// Latency : one cycle; a word accepted on edge N is presented on outk from cycle N+1.
// Backpres: in_ready drops only for words aimed at a full, stalled channel; other channels keep flowing.
// Optional: define DEMUX_STATS_EN to add stat_cnt, four 16-bit wrapping delivered-word counters.
module demux_1_4_stream #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [63:0]           stat_cnt
`endif
);

  logic [DATA_WIDTH-1:0] data_q [4];
  logic [DATA_WIDTH-1:0] data_d [4];
  logic [3:0]            vld_q;
  logic [3:0]            vld_d;
  logic [3:0]            load;
  logic [3:0]            drain;
  logic                  in_xfer;

  // A channel can take a word when it is empty or is being emptied on this same edge.
  assign in_ready = rst_n & (~vld_q[in_sel] | out_ready[in_sel]);
  assign in_xfer  = in_valid & in_ready;

  // Per-channel load/drain decode and next state; a simultaneous load and drain keeps valid high.
  always_comb begin
    load  = '0;
    drain = '0;
    vld_d = vld_q;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      load[k]   = in_xfer & (in_sel == 2'(k));
      drain[k]  = vld_q[k] & out_ready[k];
      if (load[k]) begin
        data_d[k] = in_data;
        vld_d[k]  = 1'b1;
      end else if (drain[k]) begin
        vld_d[k]  = 1'b0;
      end
    end
  end

  // Channel registers; reset clears both valid and data, dropping anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < 4; k++) data_q[k] <= data_d[k];
    end
  end

  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out_valid = vld_q;

`ifdef DEMUX_STATS_EN
  logic [15:0] cnt_q [4];

  // Delivered-word counters, one per channel, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain[k]) cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  assign stat_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Testbench for demux_1_4_stream: directed routing/backpressure/reset steps, then a
// randomized run scored against per-channel queues; stats counters checked when DEMUX_STATS_EN is set.
module tb_demux_1_4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0, out1, out2, out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
`ifdef DEMUX_STATS_EN
  logic [63:0] stat_cnt;
`endif

  logic [15:0] outs [4];
  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;

  int checks = 0;
  int errors = 0;

  demux_1_4_stream #(.DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: words accepted but not yet delivered, per channel, in acceptance order.
  logic [15:0] sb [4][$];
  int          deliv [4];

  function automatic bit model_busy();
    return (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0;
  endfunction

  initial begin
    logic       exp_rdy;
    logic       acc;
    logic [3:0] drn;
    logic       pend;
    int         sent;
    int         cyc;

    // ---------------- reset with in_valid held high ----------------
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hFFFF; out_ready = 4'h0;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out0", 64'(out0), 64'h0);
    check("rst_out1", 64'(out1), 64'h0);
    check("rst_out2", 64'(out2), 64'h0);
    check("rst_out3", 64'(out3), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    in_valid = 1'b0; rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'h1);

    // ---------------- routing, all consumers ready ----------------
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] w;
      w = {4'hA + 4'(i), 4'(i), 4'hA + 4'(i), 4'(i)};
      in_data = w; in_sel = 2'(i); in_valid = 1'b1;
      #1;
      check("route_in_ready", 64'(in_ready), 64'h1);
      tick();
      check("route_valid", 64'(out_valid), 64'(4'b0001 << i));
      check("route_data", 64'(outs[i]), 64'(w));
    end
    in_valid = 1'b0;
    tick();
    check("route_drained", 64'(out_valid), 64'h0);

    // ---------------- backpressure on channel 2 ----------------
    out_ready = 4'h0;
    in_data = 16'h1111; in_sel = 2'd2; in_valid = 1'b1;
    tick();
    check("bp_first_valid", 64'(out_valid), 64'h4);
    check("bp_first_data", 64'(out2), 64'h1111);
    in_data = 16'h2222;
    #1;
    check("bp_stall_in_ready", 64'(in_ready), 64'h0);
    tick();
    check("bp_held_data", 64'(out2), 64'h1111);
    check("bp_held_valid", 64'(out_valid), 64'h4);
    out_ready = 4'h4;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'h1);
    tick();
    check("bp_swap_data", 64'(out2), 64'h2222);
    check("bp_swap_valid", 64'(out_valid), 64'h4);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(out_valid), 64'h0);

    // ---------------- channel independence ----------------
    out_ready = 4'h0;
    in_data = 16'hAAAA; in_sel = 2'd0; in_valid = 1'b1;
    tick();
    out_ready = 4'h8;
    in_data = 16'h5555; in_sel = 2'd3;
    #1;
    check("indep_in_ready", 64'(in_ready), 64'h1);
    tick();
    check("indep_out3", 64'(out3), 64'h5555);
    check("indep_valid", 64'(out_valid), 64'h9);
    check("indep_out0", 64'(out0), 64'hAAAA);
    in_valid = 1'b0;
    tick();
    check("indep_drain3", 64'(out_valid), 64'h1);

    // ---------------- reset mid-operation ----------------
    out_ready = 4'h0;
    in_data = 16'h1234; in_sel = 2'd1; in_valid = 1'b1;
    tick();
    in_data = 16'h4321; in_sel = 2'd3;
    tick();
    in_valid = 1'b0;
    check("midrst_full", 64'(out_valid), 64'hB);
    rst_n = 1'b0;
    tick();
    check("midrst_cleared", 64'(out_valid), 64'h0);
    rst_n = 1'b1; out_ready = 4'hF;
    tick();
    check("midrst_no_stale_a", 64'(out_valid), 64'h0);
    tick();
    check("midrst_no_stale_b", 64'(out_valid), 64'h0);
`ifdef DEMUX_STATS_EN
    check("stats_after_reset", stat_cnt, 64'h0);
`endif

    // ---------------- randomized traffic against the queue model ----------------
    for (int k = 0; k < 4; k++) deliv[k] = 0;
    sent = 0; cyc = 0; pend = 1'b0;
    while ((sent < 1000 || model_busy()) && cyc < 30000) begin
      cyc++;
      out_ready = 4'($urandom_range(0, 15));
      if (sent >= 1000) out_ready = 4'hF;
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_data = 16'($urandom); in_sel = 2'($urandom_range(0, 3)); in_valid = 1'b1; pend = 1'b1;
      end else if (!pend) begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = (sb[in_sel].size() == 0) || out_ready[in_sel];
      check("rand_in_ready", 64'(in_ready), 64'(exp_rdy));
      for (int k = 0; k < 4; k++) begin
        check("rand_valid", 64'(out_valid[k]), 64'(sb[k].size() != 0));
        if (sb[k].size() != 0) check("rand_data", 64'(outs[k]), 64'(sb[k][0]));
        drn[k] = (sb[k].size() != 0) && out_ready[k];
      end
      acc = in_valid && exp_rdy;
      tick();
      for (int k = 0; k < 4; k++) begin
        if (drn[k]) begin
          void'(sb[k].pop_front());
          deliv[k]++;
        end
      end
      if (acc) begin
        sb[in_sel].push_back(in_data);
        sent++;
        pend = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("rand_no_timeout", 64'(cyc < 30000), 64'h1);
    check("rand_all_sent", 64'(sent), 64'd1000);
    check("rand_no_loss", 64'(model_busy()), 64'h0);
    check("rand_total_delivered", 64'(deliv[0] + deliv[1] + deliv[2] + deliv[3]), 64'd1000);

`ifdef DEMUX_STATS_EN
    for (int k = 0; k < 4; k++)
      check("stats_count", 64'(stat_cnt[16*k +: 16]), 64'(deliv[k] % 65536));

    // ---------------- counter wrap on channel 0 ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 4'h1; in_sel = 2'd0; in_valid = 1'b1; in_data = 16'h0F0F;
    // First edge only loads; each of the following 65535 edges drains one word and loads the next.
    for (int n = 0; n < 65536; n++) tick();
    check("wrap_ffff", 64'(stat_cnt[15:0]), 64'hFFFF);
    in_valid = 1'b0;
    tick();
    check("wrap_zero", 64'(stat_cnt[15:0]), 64'h0);
    check("wrap_others_zero", 64'(stat_cnt[63:16]), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
